// File: rtl/sel_pri_pkg.sv
// Shared definitions for the selectable-priority arbiter: mode encodings and
// the index-width helper used to size source indices.
package sel_pri_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  // Ceiling log2, floored at 1 so a 2-source arbiter still gets an index bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/sel_pri_pick.sv
// Rotated priority search: scans req upward from 'start', wrapping modulo N,
// and reports the first set bit as a one-hot vector and as an index.
module sel_pri_pick
  import sel_pri_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] idx,
  output logic          found
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  // Candidate position for each search offset; start is always < N, so one
  // conditional subtraction implements the modulo.
  logic [IW-1:0] pos [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pos
    logic [IW:0] sum;
    assign sum     = {1'b0, start} + (IW+1)'(gi);
    assign pos[gi] = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
  end

  always_comb begin
    gnt_oh = '0;
    idx    = '0;
    found  = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!found && req[pos[off]]) begin
        found          = 1'b1;
        gnt_oh[pos[off]] = 1'b1;
        idx            = pos[off];
      end
    end
  end

endmodule

// File: rtl/sel_pri_arb.sv
// N-source arbiter with fixed or round-robin priority, feeding a single
// registered output slot with valid/ready backpressure.
module sel_pri_arb
  import sel_pri_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int IW    = clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] src,
  input  logic [N-1:0]       req,
  input  logic               mode,
  output logic [N-1:0]       gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IW-1:0]      out_src
);

  logic             load;
  logic             grant;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    pick_start;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     pick_oh;
  logic             pick_found;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] masked [N];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_src_q, out_src_d;

  assign pick_start = (arb_mode_e'(mode) == MODE_RR) ? ptr_q : '0;

  sel_pri_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // The slot can take a new result when empty or being drained this cycle.
  assign load  = !out_valid_q || out_ready;
  assign grant = reset_n && load && pick_found;
  assign gnt   = grant ? pick_oh : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked[gi] = {WIDTH{pick_oh[gi]}} & src[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | masked[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_src_d   = pick_idx;
        if (arb_mode_e'(mode) == MODE_RR) begin
          ptr_d = (pick_idx == IW'(N-1)) ? '0 : pick_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_src_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/sel_pri_arb.md
SEL_PRI_ARB -- requirements
Module: sel_pri_arb

Interface
REQ-001 Parameter: WIDTH, default 32, data width of each source and of the result.
REQ-002 Parameter: N, default 3, number of sources, legal range 2..16.
REQ-003 Parameter: IW, default clog2(N), width of the source index.
REQ-004 Port: clk  input  1  single clock, rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: src  input  N*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: req  input  N  per-source request; bit i qualifies source i.
REQ-008 Port: mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-009 Port: gnt  output  N  one-hot grant; source i is consumed in the cycle gnt[i]=1.
REQ-010 Port: out_valid  output  1  registered result valid.
REQ-011 Port: out_ready  input  1  downstream accepts the result when out_valid=1.
REQ-012 Port: out_data  output  WIDTH  registered selected data.
REQ-013 Port: out_src  output  IW  registered index of the granted source.

Function
REQ-014 load = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-015 When load=1 and req!=0, gnt SHALL be one-hot for the winner in the same cycle.
REQ-016 When load=0 or req=0, gnt SHALL be 0.
REQ-017 Fixed mode: the winner is the lowest set index of req.
REQ-018 Round-robin mode: the search starts at pointer ptr and ascends modulo N; the winner is the first set req bit.
REQ-019 On a grant to index k in round-robin mode, ptr SHALL become (k+1) mod N at the next edge; wrap from N-1 gives 0.
REQ-020 In fixed mode ptr SHALL hold its value; a mode change takes effect at the next arbitration with ptr preserved.
REQ-021 On the edge where a grant occurs: out_valid<=1, out_data<=src[k], out_src<=k; latency from req to out_valid is one cycle.
REQ-022 On the edge where load=1 and req=0: out_valid<=0, out_data<=0, out_src<=0 (zero result when no source is selected).
REQ-023 When load=0 (out_valid=1, out_ready=0), out_valid, out_data, out_src and ptr SHALL hold; stalls are lossless and requesters are not granted.
REQ-024 With out_valid=1 and out_ready=1 and req!=0, accept and new load occur in the same edge; full throughput is one result per cycle.
REQ-025 req and src SHALL be sampled only in grant cycles; changes outside them have no effect.
REQ-026 The block SHALL introduce no combinational path from out_ready to out_data or out_valid, but gnt SHALL depend combinationally on out_ready, req, mode and ptr.

Reset
REQ-027 When reset_n=0, immediately: out_valid=0, out_data=0, out_src=0, ptr=0, gnt=0.
REQ-028 A reset asserted mid-stall SHALL discard the held result; no grant is issued while reset_n=0.
REQ-029 The first edge after reset_n rises SHALL arbitrate normally with ptr=0.

Structure
REQ-030 Package sel_pri_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the clog2 helper.
REQ-031 The combinational sub-module sel_pri_pick (inputs req and start index; outputs one-hot and index plus any flag) SHALL implement the rotated priority search; fixed mode drives start=0.
REQ-032 sel_pri_arb SHALL contain only the pick instance, the output register, the ptr register and the load logic.

Verification
REQ-033 Reset defaults: N=3; hold reset_n=0 with req=3'b111 -> gnt=0, out_valid=0, out_data=0, ptr=0.
REQ-034 Fixed priority: mode=0, out_ready=1, req=3'b110, src1=0x11111111, src2=0x22222222 -> gnt=3'b010; next cycle out_data=0x11111111, out_src=1.
REQ-035 Round-robin wrap: mode=1, req=3'b111 held for 4 cycles, out_ready=1 -> gnt sequence 001,010,100,001; out_src sequence 0,1,2,0.
REQ-036 Stall: out_valid=1, out_ready=0 for 3 cycles with req=3'b001 -> gnt=0 and out_data held; release out_ready -> same-cycle grant, new data on the next edge.
REQ-037 Empty: out_ready=1, req=0 after a valid result -> next cycle out_valid=0, out_data=0, out_src=0.
REQ-038 Mode switch and reset: with ptr=2, switch to mode=0 with req=3'b101 -> grant to 0 and ptr still 2; assert reset_n=0 mid-stall -> outputs zero asynchronously.
